uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 119 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a byte-wide UART transmitter.
// Ports: CLK/RST (sync, active-low), ALU_* (2-byte requester A), RF_* (1-byte requester B),
//        TX_P_Data/TX_Data_Valid/TX_Busy (UART side), Frames_Sent, Ctrl_Busy.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [2*DATA_WIDTH-1:0] ALU_Data,
  input  logic                    ALU_Valid,
  output logic                    ALU_Ready,
  input  logic [DATA_WIDTH-1:0]   RF_Data,
  input  logic                    RF_Valid,
  output logic                    RF_Ready,
  output logic [DATA_WIDTH-1:0]   TX_P_Data,
  output logic                    TX_Data_Valid,
  input  logic                    TX_Busy,
  output logic [7:0]              Frames_Sent,
  output logic                    Ctrl_Busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_START,
    S_WAIT_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                    r_last_b;
  logic [2*DATA_WIDTH-1:0] r_hold;
  logic [1:0]              r_bytes;
  logic [DATA_WIDTH-1:0]   r_tx_data;
  logic [7:0]              r_frames;

  logic w_idle;
  logic w_grant_a;
  logic w_grant_b;
  logic w_done;
  logic w_more;

  // state register
  always_ff @(posedge CLK) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant_a || w_grant_b) w_next = S_SEND;
      end
      S_SEND: begin
        if (!TX_Busy) w_next = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (TX_Busy) w_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!TX_Busy) w_next = w_more ? S_SEND : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // outputs and grant decode; everything gated while reset is held
  always_comb begin
    w_idle        = RST && (r_state == S_IDLE);
    // tie goes to whichever requester was not served last
    w_grant_a     = w_idle && ALU_Valid && (!RF_Valid || r_last_b);
    w_grant_b     = w_idle && RF_Valid && (!ALU_Valid || !r_last_b);
    w_done        = (r_state == S_WAIT_DONE) && !TX_Busy;
    w_more        = (r_bytes > 2'd1);
    ALU_Ready     = w_grant_a;
    RF_Ready      = w_grant_b;
    TX_Data_Valid = RST && (r_state == S_SEND) && !TX_Busy;
    Ctrl_Busy     = RST && (r_state != S_IDLE);
  end

  // datapath: the current byte is preloaded so it is
  // already on TX_P_Data during the whole SEND state
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_last_b  <= 1'b1;
      r_hold    <= '0;
      r_bytes   <= 2'd0;
      r_tx_data <= '0;
      r_frames  <= 8'd0;
    end else begin
      if (w_grant_a) begin
        r_hold    <= ALU_Data;
        r_bytes   <= 2'd2;
        r_last_b  <= 1'b0;
        r_tx_data <= ALU_Data[DATA_WIDTH-1:0];
      end else if (w_grant_b) begin
        r_hold    <= {{DATA_WIDTH{1'b0}}, RF_Data};
        r_bytes   <= 2'd1;
        r_last_b  <= 1'b1;
        r_tx_data <= RF_Data;
      end
      if (w_done) begin
        r_frames <= r_frames + 8'd1;
        r_bytes  <= r_bytes - 2'd1;
        if (w_more) begin
          r_hold    <= r_hold >> DATA_WIDTH;
          r_tx_data <= r_hold[2*DATA_WIDTH-1:DATA_WIDTH];
        end
      end
    end
  end

  assign TX_P_Data   = r_tx_data;
  assign Frames_Sent = r_frames;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a UART model
// that stays busy 11 cycles after each load strobe.
module tb_uart_tx_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] ALU_Data = 16'h0;
  logic        ALU_Valid = 1'b0;
  logic        ALU_Ready;
  logic [7:0]  RF_Data = 8'h0;
  logic        RF_Valid = 1'b0;
  logic        RF_Ready;
  logic [7:0]  TX_P_Data;
  logic        TX_Data_Valid;
  logic        TX_Busy;
  logic [7:0]  Frames_Sent;
  logic        Ctrl_Busy;

  logic tx_force = 1'b0;
  int   tx_cnt = 0;
  int   cyc = 0;

  int n_checks = 0;
  int n_errors = 0;

  int   n_strb = 0;
  int   n_grant = 0;
  int   both_hi = 0;
  int   strb_busy = 0;
  int   rf_rdy_cnt = 0;
  logic [7:0] strb_byte [0:1023];
  logic       grant_b   [0:1023];
  int         grant_cyc [0:1023];

  uart_tx_arbiter #(.DATA_WIDTH(8)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .ALU_Data      (ALU_Data),
    .ALU_Valid     (ALU_Valid),
    .ALU_Ready     (ALU_Ready),
    .RF_Data       (RF_Data),
    .RF_Valid      (RF_Valid),
    .RF_Ready      (RF_Ready),
    .TX_P_Data     (TX_P_Data),
    .TX_Data_Valid (TX_Data_Valid),
    .TX_Busy       (TX_Busy),
    .Frames_Sent   (Frames_Sent),
    .Ctrl_Busy     (Ctrl_Busy)
  );

  always #5 CLK = ~CLK;

  assign TX_Busy = (tx_cnt != 0) || tx_force;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (TX_Data_Valid)   tx_cnt <= 11;
    else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
  end

  always @(negedge CLK) begin
    if (TX_Data_Valid) begin
      strb_byte[n_strb & 1023] <= TX_P_Data;
      n_strb <= n_strb + 1;
      if (TX_Busy) strb_busy <= strb_busy + 1;
    end
    if (ALU_Valid && ALU_Ready) begin
      grant_b[n_grant & 1023]   <= 1'b0;
      grant_cyc[n_grant & 1023] <= cyc;
      n_grant <= n_grant + 1;
    end else if (RF_Valid && RF_Ready) begin
      grant_b[n_grant & 1023]   <= 1'b1;
      grant_cyc[n_grant & 1023] <= cyc;
      n_grant <= n_grant + 1;
    end
    if (ALU_Ready && RF_Ready) both_hi <= both_hi + 1;
    if (RF_Ready) rf_rdy_cnt <= rf_rdy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  task automatic wait_grant(input int target);
    bit ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge CLK); #1;
      if (n_grant >= target) begin
        ok = 1;
        break;
      end
    end
    chk("grant_wait", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge CLK);
      if (!Ctrl_Busy) begin
        ok = 1;
        break;
      end
    end
    chk("idle_wait", 32'(ok), 32'd1);
  endtask

  task automatic send_rf(input logic [7:0] d);
    int tgt;
    @(posedge CLK); #1;
    RF_Data  = d;
    RF_Valid = 1'b1;
    tgt = n_grant + 1;
    wait_grant(tgt);
    RF_Valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    int sb, gb, rb;
    bit ok;

    // reset state with both requesters already asserting
    ALU_Data  = 16'hC3D4;
    RF_Data   = 8'h5A;
    ALU_Valid = 1'b1;
    RF_Valid  = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_alu_rdy", 32'(ALU_Ready), 32'd0);
    chk("rst_rf_rdy", 32'(RF_Ready), 32'd0);
    chk("rst_busy", 32'(Ctrl_Busy), 32'd0);
    chk("rst_txv", 32'(TX_Data_Valid), 32'd0);
    chk("rst_txd", 32'(TX_P_Data), 32'h0);
    chk("rst_frames", 32'(Frames_Sent), 32'd0);

    // round robin with both valids held
    sb = n_strb;
    gb = n_grant;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    chk("rr_first_a", 32'(ALU_Ready), 32'd1);
    chk("rr_first_b", 32'(RF_Ready), 32'd0);
    wait_grant(gb + 4);
    ALU_Valid = 1'b0;
    RF_Valid  = 1'b0;
    wait_idle();
    chk("rr_g0", 32'(grant_b[gb]), 32'd0);
    chk("rr_g1", 32'(grant_b[gb + 1]), 32'd1);
    chk("rr_g2", 32'(grant_b[gb + 2]), 32'd0);
    chk("rr_g3", 32'(grant_b[gb + 3]), 32'd1);
    chk("rr_gap_a", 32'(grant_cyc[gb + 1] - grant_cyc[gb]), 32'd27);
    chk("rr_gap_b", 32'(grant_cyc[gb + 2] - grant_cyc[gb + 1]), 32'd14);
    chk("rr_both", 32'(both_hi), 32'd0);
    chk("rr_nstrb", 32'(n_strb - sb), 32'd6);
    chk("rr_b0", 32'(strb_byte[sb]), 32'hD4);
    chk("rr_b1", 32'(strb_byte[sb + 1]), 32'hC3);
    chk("rr_b2", 32'(strb_byte[sb + 2]), 32'h5A);
    chk("rr_b5", 32'(strb_byte[sb + 5]), 32'h5A);
    chk("rr_frames", 32'(Frames_Sent), 32'd6);

    // single RF byte
    do_reset();
    sb = n_strb;
    rb = rf_rdy_cnt;
    send_rf(8'hA5);
    chk("rf_rdy_len", 32'(rf_rdy_cnt - rb), 32'd1);
    chk("rf_nstrb", 32'(n_strb - sb), 32'd1);
    chk("rf_byte", 32'(strb_byte[sb]), 32'hA5);
    chk("rf_frames", 32'(Frames_Sent), 32'd1);
    chk("rf_txd_hold", 32'(TX_P_Data), 32'hA5);

    // two ALU bytes, low byte first
    do_reset();
    sb = n_strb;
    @(posedge CLK); #1;
    ALU_Data  = 16'h1234;
    ALU_Valid = 1'b1;
    wait_grant(n_grant + 1);
    ALU_Valid = 1'b0;
    wait_idle();
    chk("alu_nstrb", 32'(n_strb - sb), 32'd2);
    chk("alu_b0", 32'(strb_byte[sb]), 32'h34);
    chk("alu_b1", 32'(strb_byte[sb + 1]), 32'h12);
    chk("alu_frames", 32'(Frames_Sent), 32'd2);

    // transmitter busy on entry to SEND
    do_reset();
    sb = n_strb;
    @(posedge CLK); #1;
    RF_Data  = 8'h3C;
    RF_Valid = 1'b1;
    wait_grant(n_grant + 1);
    RF_Valid = 1'b0;
    tx_force = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    chk("hold_nstrb", 32'(n_strb - sb), 32'd0);
    chk("hold_busy", 32'(Ctrl_Busy), 32'd1);
    tx_force = 1'b0;
    wait_idle();
    chk("hold_nstrb2", 32'(n_strb - sb), 32'd1);
    chk("hold_byte", 32'(strb_byte[sb]), 32'h3C);
    chk("hold_frames", 32'(Frames_Sent), 32'd1);

    // reset during WAIT_DONE of the first ALU byte
    do_reset();
    sb = n_strb;
    @(posedge CLK); #1;
    ALU_Data  = 16'hBEEF;
    ALU_Valid = 1'b1;
    wait_grant(n_grant + 1);
    ALU_Valid = 1'b0;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (n_strb > sb && TX_Busy) begin
        ok = 1;
        break;
      end
    end
    chk("mid_wait", 32'(ok), 32'd1);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_idle", 32'(Ctrl_Busy), 32'd0);
    chk("mid_frames", 32'(Frames_Sent), 32'd0);
    repeat (30) @(posedge CLK);
    #1;
    chk("mid_nstrb", 32'(n_strb - sb), 32'd1);
    chk("mid_byte", 32'(strb_byte[sb]), 32'hEF);
    chk("mid_frames2", 32'(Frames_Sent), 32'd0);

    // frame counter wrap
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send_rf(8'(i));
      if (i == 254) chk("wrap_ff", 32'(Frames_Sent), 32'hFF);
    end
    chk("wrap_00", 32'(Frames_Sent), 32'h00);
    chk("strb_while_busy", 32'(strb_busy), 32'd0);
    chk("both_ready", 32'(both_hi), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
